// File: rtl/key_event.sv
// Key press classifier: short / long / auto-repeat events plus the modulation-mode register.
// Optional auto-repeat while a long press is held is enabled by defining KEY_REPEAT_EN.
module key_event #(
    parameter int LONG_CYC   = 50_000_000,
    parameter int REPEAT_CYC = 10_000_000,
    parameter int CNT_W      = 26,
    parameter int MODE_NUM   = 3,
    parameter int MODE_W     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_in,
    output logic              short_pulse,
    output logic              long_pulse,
    output logic              rpt_pulse,
    output logic [MODE_W-1:0] mode,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        LONG  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(MODE_NUM - 1);

    if (LONG_CYC < 2 || REPEAT_CYC < 2 || MODE_NUM < 2 ||
        (64'd1 << MODE_W) < 64'(MODE_NUM) ||
        (64'd1 << CNT_W) < 64'(LONG_CYC) ||
        (64'd1 << CNT_W) < 64'(REPEAT_CYC)) begin : g_param_err
        $error("key_event: parameter out of range");
    end

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              key_d;
    logic [MODE_W-1:0] mode_nx, mode_inc;
    logic              short_nx, long_nx;

    assign mode_inc = (mode == MODE_LAST) ? '0 : mode + 1'b1;

`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYC - 1);
    logic rpt_nx;
`else
    assign rpt_pulse = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        mode_nx  = mode;
        short_nx = 1'b0;
        long_nx  = 1'b0;
`ifdef KEY_REPEAT_EN
        rpt_nx   = 1'b0;
`endif
        case (state)
            IDLE: begin
                // key_d starts at 0, so a key held through reset never looks like a fall
                if (key_d && !key_in) begin
                    state_nx = PRESS;
                    cnt_nx   = '0;
                end
            end
            PRESS: begin
                // release wins over the long threshold on the same edge
                if (key_in) begin
                    short_nx = 1'b1;
                    mode_nx  = mode_inc;
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == LONG_LAST) begin
                    long_nx  = 1'b1;
                    mode_nx  = '0;
                    state_nx = LONG;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx   = cnt + 1'b1;
                end
            end
            LONG: begin
                if (key_in) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
`ifdef KEY_REPEAT_EN
                    if (cnt == RPT_LAST) begin
                        rpt_nx  = 1'b1;
                        mode_nx = mode_inc;
                        cnt_nx  = '0;
                    end else begin
                        cnt_nx  = cnt + 1'b1;
                    end
`else
                    cnt_nx = '0;
`endif
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            key_d       <= 1'b0;
            short_pulse <= 1'b0;
            long_pulse  <= 1'b0;
            mode        <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            key_d       <= key_in;
            short_pulse <= short_nx;
            long_pulse  <= long_nx;
            mode        <= mode_nx;
            busy        <= (state_nx != IDLE);
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clk) begin
        if (rst) rpt_pulse <= 1'b0;
        else     rpt_pulse <= rpt_nx;
    end
`endif

endmodule

// File: tb/tb_key_event.sv
// Bench for key_event: press-timeline reference model checked every cycle, plus directed literal checks.
module tb_key_event;
    localparam int LONG_CYC   = 8;
    localparam int REPEAT_CYC = 4;
    localparam int CNT_W      = 4;
    localparam int MODE_NUM   = 3;
    localparam int MODE_W     = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_in = 1'b1;
    logic short_pulse, long_pulse, rpt_pulse, busy;
    logic [MODE_W-1:0] mode;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    key_event #(
        .LONG_CYC(LONG_CYC), .REPEAT_CYC(REPEAT_CYC), .CNT_W(CNT_W),
        .MODE_NUM(MODE_NUM), .MODE_W(MODE_W)
    ) dut (
        .clk(clk), .rst(rst), .key_in(key_in),
        .short_pulse(short_pulse), .long_pulse(long_pulse), .rpt_pulse(rpt_pulse),
        .mode(mode), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a press is described by the number of edges since its fall (m_t);
    // events are decided from that elapsed time alone.
    bit m_prev, m_active, m_long;
    int m_t, m_mode;
    bit e_short, e_long, e_rpt;

    task automatic model_step(input logic r, input logic k);
        e_short = 0; e_long = 0; e_rpt = 0;
        if (r) begin
            m_prev = 0; m_active = 0; m_long = 0; m_t = 0; m_mode = 0;
            return;
        end
        if (!m_active) begin
            if (m_prev && !k) begin
                m_active = 1; m_long = 0; m_t = 0;
            end
        end else begin
            m_t++;
            if (k) begin
                if (!m_long) begin
                    e_short = 1;
                    m_mode = (m_mode + 1) % MODE_NUM;
                end
                m_active = 0;
            end else if (!m_long) begin
                if (m_t == LONG_CYC) begin
                    e_long = 1; m_mode = 0; m_long = 1;
                end
            end else begin
`ifdef KEY_REPEAT_EN
                if ((m_t - LONG_CYC) % REPEAT_CYC == 0) begin
                    e_rpt = 1;
                    m_mode = (m_mode + 1) % MODE_NUM;
                end
`endif
            end
        end
        m_prev = k;
    endtask

    always @(posedge clk) begin
        model_step(rst, key_in);
        #2;
        chk("m_short", short_pulse, e_short);
        chk("m_long",  long_pulse,  e_long);
        chk("m_rpt",   rpt_pulse,   e_rpt);
        chk("m_mode",  mode,        m_mode);
        chk("m_busy",  busy,        m_active);
    end

    task automatic step(input logic k);
        key_in = k;
        @(posedge clk);
        #1;
    endtask

    int base;
    int len;
    logic k;

    initial begin
        // reset, then idle high
        rst = 1'b1;
        repeat (2) step(1'b1);
        chk("rst_busy", busy, 0);
        chk("rst_mode", mode, 0);
        chk("rst_short", short_pulse, 0);
        rst = 1'b0;
        repeat (10) step(1'b1);
        chk("idle_busy", busy, 0);
        chk("idle_long", long_pulse, 0);

        // three short presses: mode 1, 2, 0
        for (int p = 0; p < 3; p++) begin
            repeat (3) step(1'b0);
            step(1'b1);
            chk("short_pulse", short_pulse, 1);
            chk("short_mode", mode, (p + 1) % 3);
            repeat (2) step(1'b1);
        end
        // bring mode to 2
        repeat (2) begin
            repeat (3) step(1'b0);
            step(1'b1);
            repeat (2) step(1'b1);
        end
        chk("pre_hold_mode", mode, 2);

        // long hold of 20 low cycles
        step(1'b0);
        for (int i = 1; i < 20; i++) begin
            step(1'b0);
            if (i == 7) chk("long_early", long_pulse, 0);
            if (i == 8) begin
                chk("long_at_8", long_pulse, 1);
                chk("long_mode", mode, 0);
            end
            if (i == 12) begin
`ifdef KEY_REPEAT_EN
                chk("rpt_at_12", rpt_pulse, 1);
                chk("rpt_mode", mode, 1);
`else
                chk("rpt_at_12", rpt_pulse, 0);
                chk("rpt_mode", mode, 0);
`endif
            end
        end
        step(1'b1);
        chk("long_rel_short", short_pulse, 0);
        chk("long_rel_busy", busy, 0);
        step(1'b1);

        // release exactly at the long threshold counts as short
`ifdef KEY_REPEAT_EN
        base = 2;
`else
        base = 0;
`endif
        step(1'b0);
        repeat (7) step(1'b0);
        chk("thr_busy", busy, 1);
        step(1'b1);
        chk("thr_short", short_pulse, 1);
        chk("thr_long", long_pulse, 0);
        chk("thr_mode", mode, (base + 1) % 3);
        step(1'b1);

        // key held low through reset is ignored until released
        rst = 1'b1;
        repeat (2) step(1'b0);
        rst = 1'b0;
        repeat (5) step(1'b0);
        chk("held_rst_busy", busy, 0);
        step(1'b1);
        step(1'b0);
        chk("after_rel_busy", busy, 1);
        step(1'b1);
        chk("after_rel_mode", mode, 1);

        // reset mid-press
        step(1'b1);
        step(1'b0);
        step(1'b0);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        step(1'b0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_mode", mode, 0);
        chk("mid_rst_short", short_pulse, 0);
        rst = 1'b0;
        step(1'b1);

        // randomized runs
        k = 1'b1;
        for (int r = 0; r < 300; r++) begin
            k = ~k;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 26) : $urandom_range(1, 9);
            for (int c = 0; c < len; c++) begin
                rst = ($urandom_range(0, 199) == 0);
                step(k);
            end
        end
        rst = 1'b0;
        repeat (3) step(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
